// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO read-side logic: arbiter state
// encoding, width helper and the FIFO's own sizing constants.
package fifo_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int DEFAULT_DATA_W = 8;

   // Binary read/write pointer width of the FIFO (depth 16 plus wrap bit).
   localparam int FIFO_PTR_W = 5;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr.sv
// Round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter
   import fifo_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   localparam int SW = IDX_W + 1;

   logic [SW-1:0]    sum;
   logic [IDX_W-1:0] cand;

   // Scan NUM_REQ positions starting at rr_ptr; the first hit wins.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      sum  = '0;
      cand = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + SW'(k);
         if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
         cand = sum[IDX_W-1:0];
         if (!any && req[cand]) begin
            any       = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-port arbiter for the async FIFO: round-robin grants with bounded
// bursts, read enable gated by owner request and empty flag, and one-hot
// steering of popped words back to their owner.
module fifo_rd_arbiter
   import fifo_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int BURST_MAX = 4
) (
   input  logic               rd_clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               fifo_empty,
   input  logic [DATA_W-1:0]  fifo_rd_data,
   output logic               fifo_rd_en,
   output logic [NUM_REQ-1:0] grant,
   output logic [DATA_W-1:0]  dout,
   output logic [NUM_REQ-1:0] dout_valid,
   output logic               busy
);

   localparam int IDX_W = clog2(NUM_REQ);
   localparam int CNT_W = clog2(BURST_MAX) + 1;

   arb_state_e         state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [IDX_W-1:0]   owner_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [CNT_W-1:0]   burst_cnt_q;
   logic               pop_dly_q;
   logic [IDX_W-1:0]   owner_dly_q;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;
   logic               pop;
   logic               burst_last;
   logic               burst_exit;
   logic [IDX_W-1:0]   ptr_next;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .gnt    (arb_gnt),
      .idx    (arb_idx),
      .any    (arb_any)
   );

   // Only the owner's request can pop, and never while the FIFO is empty.
   assign pop        = (state_q == BURST) && req[owner_q] && !fifo_empty;
   assign burst_last = (burst_cnt_q == CNT_W'(BURST_MAX - 1));
   assign burst_exit = (pop && burst_last) || !req[owner_q] || fifo_empty;
   assign ptr_next   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

   // Grant FSM: pick a winner in IDLE, count pops in BURST, rotate on exit.
   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_any && !fifo_empty) begin
                  state_q     <= BURST;
                  grant_q     <= arb_gnt;
                  owner_q     <= arb_idx;
                  burst_cnt_q <= '0;
               end else begin
                  grant_q <= '0;
               end
            end
            BURST: begin
               if (burst_exit) begin
                  state_q  <= IDLE;
                  grant_q  <= '0;
                  rr_ptr_q <= ptr_next;
               end else if (pop) begin
                  burst_cnt_q <= burst_cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   // Remember who popped so the word arriving next cycle is steered to them.
   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         pop_dly_q   <= 1'b0;
         owner_dly_q <= '0;
      end else begin
         pop_dly_q   <= pop;
         owner_dly_q <= owner_q;
      end
   end

   // One-hot data-valid for the consumer whose pop produced this word.
   always_comb begin
      dout_valid = '0;
      if (pop_dly_q) dout_valid[owner_dly_q] = 1'b1;
   end

   assign fifo_rd_en = pop;
   assign grant      = grant_q;
   assign dout       = fifo_rd_data;
   assign busy       = (state_q == BURST);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: FIFO stub plus a turn-based reference model,
// directed scenarios followed by randomized request/push traffic.
module tb_fifo_rd_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 8;
   localparam int BURST_MAX = 4;

   logic               clk;
   logic               rst_n;
   logic [NUM_REQ-1:0] req;
   logic               fifo_empty;
   logic [DATA_W-1:0]  fifo_rd_data;
   logic               fifo_rd_en;
   logic [NUM_REQ-1:0] grant;
   logic [DATA_W-1:0]  dout;
   logic [NUM_REQ-1:0] dout_valid;
   logic               busy;

   fifo_rd_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .BURST_MAX (BURST_MAX)
   ) dut (
      .rd_clk       (clk),
      .rst_n        (rst_n),
      .req          (req),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .grant        (grant),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: whose turn it is, where the next search starts,
   // how many words this turn has taken, and what is due for delivery.
   int               m_owner    = -1;
   int               m_ptr      = 0;
   int               m_pops     = 0;
   int               m_dv_owner = -1;
   logic [DATA_W-1:0] m_dv_word = '0;
   logic [DATA_W-1:0] mq[$];
   logic [DATA_W-1:0] fq[$];

   // Observation records of DUT behaviour.
   int               gq[$];
   int               pq[$];
   int               dq[$];
   logic [NUM_REQ-1:0] prev_grant = '0;
   int               cur_pops    = 0;
   int               rd_en_count = 0;
   logic             obs_rd      = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NUM_REQ; i++) if (v[i] && r < 0) r = i;
      return r;
   endfunction

   task automatic push(input logic [DATA_W-1:0] w);
      mq.push_back(w);
      fq.push_back(w);
      fifo_empty = 1'b0;
   endtask

   // One clock: check outputs mid-cycle, then advance model and FIFO stub.
   task automatic step();
      logic [NUM_REQ-1:0] e_gnt;
      logic [NUM_REQ-1:0] e_dv;
      logic [NUM_REQ-1:0] req_s;
      logic               e_pop;
      logic               emp_s;
      logic               rd_s;
      @(negedge clk);
      e_gnt = (m_owner >= 0) ? NUM_REQ'(1 << m_owner) : '0;
      e_pop = (m_owner >= 0) && req[m_owner] && !fifo_empty;
      e_dv  = (m_dv_owner >= 0) ? NUM_REQ'(1 << m_dv_owner) : '0;
      chk("grant", grant, e_gnt);
      chk("rd_en", fifo_rd_en, e_pop);
      chk("dout_valid", dout_valid, e_dv);
      chk("busy", busy, m_owner >= 0);
      if (e_dv != 0) chk("dout", dout, m_dv_word);
      if (dout_valid == 4'b0100) dq.push_back(int'(dout));
      if (grant == 0 && prev_grant != 0) pq.push_back(cur_pops);
      if (grant != 0 && prev_grant == 0) begin
         gq.push_back(oh_idx(grant));
         cur_pops = 0;
      end
      if (fifo_rd_en) begin
         cur_pops++;
         rd_en_count++;
      end
      prev_grant = grant;
      obs_rd = fifo_rd_en;
      req_s  = req;
      emp_s  = fifo_empty;
      rd_s   = fifo_rd_en;
      @(posedge clk);
      #1;
      if (m_owner < 0) begin
         m_dv_owner = -1;
         if (req_s != 0 && !emp_s) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               if (m_owner < 0 && req_s[(m_ptr + k) % NUM_REQ]) m_owner = (m_ptr + k) % NUM_REQ;
            end
            m_pops = 0;
         end
      end else begin
         m_dv_owner = e_pop ? m_owner : -1;
         if (e_pop) begin
            if (mq.size() > 0) m_dv_word = mq.pop_front();
            m_pops++;
         end
         if ((e_pop && m_pops == BURST_MAX) || !req_s[m_owner] || emp_s) begin
            m_ptr   = (m_owner + 1) % NUM_REQ;
            m_owner = -1;
         end
      end
      if (rd_s && fq.size() > 0) fifo_rd_data = fq.pop_front();
      fifo_empty = (fq.size() == 0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_busy", busy, 0);
      m_owner = -1; m_ptr = 0; m_pops = 0; m_dv_owner = -1;
      mq.delete(); fq.delete(); gq.delete(); pq.delete(); dq.delete();
      req = '0; fifo_empty = 1'b1;
      prev_grant = '0; cur_pops = 0; rd_en_count = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; req = '0; fifo_empty = 1'b1; fifo_rd_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("init_grant", grant, 0);
      chk("init_dout_valid", dout_valid, 0);
      rst_n = 1'b1;

      // Reset in the middle of a burst with a delivery pending.
      for (int i = 0; i < 16; i++) push(8'(i));
      req = 4'b1111;
      step(); step();
      chk("pre_rst_dv_pending", dout_valid, 4'b0001);
      req = 4'b1111;
      do_reset();
      for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
      req = 4'b1111;
      repeat (3) step();
      chk("first_grant", (gq.size() > 0) ? gq[0] : -1, 0);

      // Fairness: 32 words, all requesting.
      do_reset();
      for (int i = 0; i < 32; i++) push(8'($urandom));
      req = 4'b1111;
      repeat (60) step();
      chk("fair_ngrants", gq.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk("fair_owner", (i < gq.size()) ? gq[i] : -1, i % NUM_REQ);
         chk("fair_pops", (i < pq.size()) ? pq[i] : -1, BURST_MAX);
      end
      chk("fair_total_pops", rd_en_count, 32);

      // Empty cut-off: two words for consumer 1.
      do_reset();
      push(8'h11); push(8'h22);
      req = 4'b0010;
      repeat (10) step();
      chk("empty_pops", rd_en_count, 2);
      chk("empty_ngrants", gq.size(), 1);
      chk("empty_burst_pops", (pq.size() > 0) ? pq[0] : -1, 2);

      // Request drop: owner 2 drops after one pop, consumer 3 waiting.
      do_reset();
      for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
      req = 4'b1100;
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = obs_rd;
         end
         chk("drop_pop_seen", seen, 1);
      end
      req = 4'b1000;
      repeat (8) step();
      chk("drop_owner", (gq.size() > 0) ? gq[0] : -1, 2);
      chk("drop_pops", (pq.size() > 0) ? pq[0] : -1, 1);
      chk("drop_next", (gq.size() > 1) ? gq[1] : -1, 3);

      // Wrap: leave the pointer at 3, then requests from 3 and 0.
      do_reset();
      push(8'h55);
      req = 4'b0100;
      repeat (4) step();
      gq.delete(); pq.delete();
      for (int i = 0; i < 12; i++) push(8'($urandom));
      req = 4'b1001;
      repeat (20) step();
      chk("wrap_g0", (gq.size() > 0) ? gq[0] : -1, 3);
      chk("wrap_g1", (gq.size() > 1) ? gq[1] : -1, 0);
      chk("wrap_g2", (gq.size() > 2) ? gq[2] : -1, 3);

      // Data steering: A then B to consumer 2.
      do_reset();
      push(8'hA5); push(8'h3C);
      req = 4'b0100;
      repeat (8) step();
      chk("steer_count", dq.size(), 2);
      chk("steer_A", (dq.size() > 0) ? dq[0] : -1, 32'hA5);
      chk("steer_B", (dq.size() > 1) ? dq[1] : -1, 32'h3C);

      // Randomized traffic with one reset in the middle.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) req = NUM_REQ'($urandom);
         if (fq.size() < 20 && $urandom_range(0, 2) == 0) push(8'($urandom));
         if (c == 1500) do_reset();
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
